cursor_field_editor: RTL



---
 rtl/cursor_pkg.sv | 18 +
 rtl/wrap_counter.sv | 35 +++
 rtl/cursor_field_editor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cursor_pkg.sv
// Shared constants and FSM encoding for the time-setting cursor editor.
package cursor_pkg;

  localparam logic [1:0] CAMPO_HORA = 2'd0;
  localparam logic [1:0] CAMPO_MIN  = 2'd1;
  localparam logic [1:0] CAMPO_SEG  = 2'd2;

  localparam int MAX_HORA = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEG  = 59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up/down counter over 0..MAX with wrap-around at both ends; increment wins over decrement.
module wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_value
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_value;

  // Value register: wraps MAX->0 going up and 0->MAX going down
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= {W{1'b0}};
    end else if (i_inc) begin
      if (r_value >= MAX_V) r_value <= {W{1'b0}};
      else                  r_value <= r_value + {{(W-1){1'b0}}, 1'b1};
    end else if (i_dec) begin
      if (r_value == {W{1'b0}}) r_value <= MAX_V;
      else if (r_value > MAX_V) r_value <= MAX_V;
      else                      r_value <= r_value - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_value <= r_value;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/cursor_field_editor.sv
// Cursor/edit front-end for setting hours, minutes and seconds, handing results to the RTC writer.
// Optional macro CURSOR_BLINK_EN makes the field highlight blink with a BLINK_DIV half-period.
module cursor_field_editor
  import cursor_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int VAL_W      = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             izquierda,
  input  logic             derecha,
  input  logic             arriba,
  input  logic             abajo,
  input  logic             programar,
  input  logic             wr_ack,
  output logic             wr_req,
  output logic [VAL_W-1:0] hora,
  output logic [VAL_W-1:0] minuto,
  output logic [VAL_W-1:0] segundo,
  output logic [1:0]       campo,
  output logic             editando,
  output logic             resaltar
);

  localparam logic [1:0] LAST_CAMPO = 2'(NUM_FIELDS - 1);

  state_t     r_state;
  logic [1:0] r_campo;
  logic       r_wr_req;
  logic       r_editando;

  logic w_edit_act;
  logic w_inc_any;
  logic w_dec_any;

  // Priority decode: programar > izquierda > derecha > arriba > abajo
  assign w_edit_act = (r_state == ST_EDIT) & ~programar;
  assign w_inc_any  = w_edit_act & ~izquierda & ~derecha & arriba;
  assign w_dec_any  = w_edit_act & ~izquierda & ~derecha & ~arriba & abajo;

  // Mode FSM with registered cursor, edit flag and write request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_campo    <= CAMPO_HORA;
      r_wr_req   <= 1'b0;
      r_editando <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (programar) begin
            r_state    <= ST_EDIT;
            r_campo    <= CAMPO_HORA;
            r_editando <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EDIT: begin
          if (programar) begin
            r_state    <= ST_WRITE;
            r_wr_req   <= 1'b1;
            r_editando <= 1'b0;
          end else if (izquierda) begin
            r_campo <= (r_campo == 2'd0) ? LAST_CAMPO : r_campo - 2'd1;
          end else if (derecha) begin
            r_campo <= (r_campo >= LAST_CAMPO) ? 2'd0 : r_campo + 2'd1;
          end else begin
            r_state <= ST_EDIT;
          end
        end
        ST_WRITE: begin
          if (wr_ack) begin
            r_state  <= ST_IDLE;
            r_wr_req <= 1'b0;
          end else begin
            r_state <= ST_WRITE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_campo    <= CAMPO_HORA;
          r_wr_req   <= 1'b0;
          r_editando <= 1'b0;
        end
      endcase
    end
  end

  wrap_counter #(.W(VAL_W), .MAX(MAX_HORA)) u_hora (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_inc_any & (r_campo == CAMPO_HORA)),
    .i_dec   (w_dec_any & (r_campo == CAMPO_HORA)),
    .o_value (hora)
  );

  wrap_counter #(.W(VAL_W), .MAX(MAX_MIN)) u_minuto (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_inc_any & (r_campo == CAMPO_MIN)),
    .i_dec   (w_dec_any & (r_campo == CAMPO_MIN)),
    .o_value (minuto)
  );

  wrap_counter #(.W(VAL_W), .MAX(MAX_SEG)) u_segundo (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_inc_any & (r_campo == CAMPO_SEG)),
    .i_dec   (w_dec_any & (r_campo == CAMPO_SEG)),
    .o_value (segundo)
  );

`ifdef CURSOR_BLINK_EN
  localparam int              CNT_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blank;
  logic             r_resaltar;

  // Blink timer restarts visible on EDIT entry and only runs while editing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= {CNT_W{1'b0}};
      r_blank     <= 1'b0;
      r_resaltar  <= 1'b0;
    end else if ((r_state == ST_IDLE) && programar) begin
      r_blink_cnt <= {CNT_W{1'b0}};
      r_blank     <= 1'b0;
      r_resaltar  <= 1'b1;
    end else if (w_edit_act) begin
      if (r_blink_cnt >= BLINK_LAST) begin
        r_blink_cnt <= {CNT_W{1'b0}};
        r_blank     <= ~r_blank;
        r_resaltar  <= r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        r_resaltar  <= ~r_blank;
      end
    end else begin
      r_blink_cnt <= {CNT_W{1'b0}};
      r_blank     <= 1'b0;
      r_resaltar  <= 1'b0;
    end
  end

  assign resaltar = r_resaltar;
`else
  assign resaltar = r_editando;
`endif

  assign wr_req   = r_wr_req;
  assign campo    = r_campo;
  assign editando = r_editando;

endmodule
